// File: rtl/mastermind_pkg.sv
// Shared code geometry, round state encoding and peg extraction for the
// guess round sequencer.
package mastermind_pkg;

   localparam int unsigned PEG_W    = 3;
   localparam int unsigned NUM_PEGS = 4;
   localparam int unsigned CODE_W   = PEG_W * NUM_PEGS;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_COMPARE,
      ST_CAPTURE,
      ST_GAME_OVER
   } round_state_t;

   function automatic logic [PEG_W-1:0] peg_of(input logic [CODE_W-1:0] code,
                                                input logic [1:0]        idx);
      case (idx)
         2'd0:    return code[2:0];
         2'd1:    return code[5:3];
         2'd2:    return code[8:6];
         default: return code[11:9];
      endcase
   endfunction

endpackage

// File: rtl/guess_validator.sv
// Combinational range check: flags a guess whose pegs are all legal colours.
// Only instantiated when GUESS_CHECK_EN is defined.
module guess_validator
   import mastermind_pkg::*;
#(
   parameter int unsigned NUM_COLOURS = 6
) (
   input  logic [CODE_W-1:0] code,
   output logic              ok
);

   always_comb begin
      ok = 1'b1;
      for (int i = 0; i < NUM_PEGS; i++) begin
         if (32'(peg_of(code, 2'(i))) >= NUM_COLOURS) ok = 1'b0;
      end
   end

endmodule

// File: rtl/guess_round_ctrl.sv
// Round sequencer feeding the peg compare stage; tracks guesses and win/lose.
// Build option GUESS_CHECK_EN rejects guesses with out-of-range pegs.
//
// state        | meaning
// ST_IDLE      | waiting for guess_submit or new_game
// ST_CLEAR     | one cycle clearing the compare stage's red/white counts
// ST_COMPARE   | four cycles walking compare_i 0..3 with compareEn high
// ST_CAPTURE   | compare stage results final, latched at the closing edge
// ST_GAME_OVER | win or lose reached; only new_game leaves
module guess_round_ctrl
   import mastermind_pkg::*;
#(
   parameter int unsigned MAX_GUESSES = 10,
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned NUM_COLOURS = 6
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              new_game,
   input  logic [CODE_W-1:0] secret_in,
   input  logic              guess_submit,
   input  logic [CODE_W-1:0] guess_in,
   input  logic [2:0]        red_in,
   input  logic [2:0]        white_in,
   output logic              resetRedWhite,
   output logic              compareEn,
   output logic [1:0]        compare_i,
   output logic [PEG_W-1:0]  curr_code,
   output logic [CODE_W-1:0] guess,
   output logic              busy,
   output logic              result_valid,
   output logic [2:0]        red_out,
   output logic [2:0]        white_out,
   output logic [CNT_W-1:0]  guess_count,
   output logic              win,
   output logic              lose,
   output logic              invalid_guess
);

   if (MAX_GUESSES < 1 || MAX_GUESSES > 15 || (MAX_GUESSES >> CNT_W) != 0 ||
       NUM_COLOURS < 1 || NUM_COLOURS > 8) begin : g_bad_params
      $error("guess_round_ctrl: illegal MAX_GUESSES/CNT_W/NUM_COLOURS");
   end

   round_state_t      state;
   logic [CODE_W-1:0] secret;
   logic [CNT_W-1:0]  cnt_next;
   logic              hit;
   logic              last_guess;
   logic              guess_ok;

`ifdef GUESS_CHECK_EN
   guess_validator #(.NUM_COLOURS(NUM_COLOURS)) u_validator (
      .code (guess_in),
      .ok   (guess_ok)
   );
`else
   assign guess_ok = 1'b1;
`endif

   assign cnt_next   = guess_count + CNT_W'(1);
   assign hit        = (red_in == 3'(NUM_PEGS));
   assign last_guess = (cnt_next == CNT_W'(MAX_GUESSES));
   assign curr_code  = peg_of(secret, compare_i);
   assign busy       = (state == ST_CLEAR) || (state == ST_COMPARE) ||
                       (state == ST_CAPTURE);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state         <= ST_IDLE;
         secret        <= '0;
         guess         <= '0;
         compare_i     <= '0;
         red_out       <= '0;
         white_out     <= '0;
         guess_count   <= '0;
         win           <= 1'b0;
         lose          <= 1'b0;
         result_valid  <= 1'b0;
         compareEn     <= 1'b0;
         invalid_guess <= 1'b0;
         resetRedWhite <= 1'b1;
      end else begin
         result_valid  <= 1'b0;
         invalid_guess <= 1'b0;
         resetRedWhite <= 1'b0;
         // new_game aborts any round in flight and wins over a same-cycle submit
         if (new_game) begin
            state         <= ST_IDLE;
            secret        <= secret_in;
            guess_count   <= '0;
            win           <= 1'b0;
            lose          <= 1'b0;
            red_out       <= '0;
            white_out     <= '0;
            compareEn     <= 1'b0;
            compare_i     <= '0;
            resetRedWhite <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (guess_submit) begin
                     if (guess_ok) begin
                        guess         <= guess_in;
                        resetRedWhite <= 1'b1;
                        compare_i     <= '0;
                        state         <= ST_CLEAR;
                     end else begin
                        invalid_guess <= 1'b1;
                     end
                  end
               end
               ST_CLEAR: begin
                  compareEn <= 1'b1;
                  compare_i <= '0;
                  state     <= ST_COMPARE;
               end
               ST_COMPARE: begin
                  if (compare_i == 2'd3) begin
                     compareEn <= 1'b0;
                     compare_i <= '0;
                     state     <= ST_CAPTURE;
                  end else begin
                     compare_i <= compare_i + 2'd1;
                  end
               end
               ST_CAPTURE: begin
                  red_out      <= red_in;
                  white_out    <= white_in;
                  result_valid <= 1'b1;
                  if (guess_count != CNT_W'(MAX_GUESSES)) guess_count <= cnt_next;
                  win          <= hit;
                  lose         <= !hit && last_guess;
                  state        <= (hit || last_guess) ? ST_GAME_OVER : ST_IDLE;
               end
               ST_GAME_OVER: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
- Round sequencer that sits directly upstream of the peg compare stage and also consumes its red/white results.
- Holds the secret code, latches each submitted guess, and pulses the compare stage's red/white clear.
- Walks the compare index 0..3 with the matching secret peg, then captures the final red/white counts.
- Tracks the guess count and flags win or lose for the display/top-level FSM.

Parameters:
MAX_GUESSES, 10, guesses allowed per game (1..15)
CNT_W, 4, width of guess_count; must hold MAX_GUESSES
NUM_COLOURS, 6, legal peg values 0..NUM_COLOURS-1 (used only by optional feature)

Ports:
clock  in  1  system clock
resetn  in  1  reset: synchronous, active-low
new_game  in  1  pulse; loads secret_in, clears game state
secret_in  in  12  secret code; peg i = bits [3i+2:3i]
guess_submit  in  1  pulse; request comparison of guess_in
guess_in  in  12  player guess, same packing
red_in  in  3  red count from compare stage
white_in  in  3  white count from compare stage
resetRedWhite  out  1  clear strobe to compare stage
compareEn  out  1  compare enable to compare stage
compare_i  out  2  current peg index
curr_code  out  3  secret peg at compare_i
guess  out  12  latched guess, held stable for the whole round
busy  out  1  high outside IDLE and GAME_OVER
result_valid  out  1  one-cycle pulse when red_out/white_out update
red_out  out  3  latched red count
white_out  out  3  latched white count
guess_count  out  CNT_W  guesses completed this game
win  out  1  sticky until new_game/reset
lose  out  1  sticky until new_game/reset
invalid_guess  out  1  one-cycle reject pulse (optional feature; else 0)

Behaviour:
- Reset (resetn=0 at posedge):
  - state=IDLE.
  - secret, guess, compare_i, red_out, white_out, guess_count = 0.
  - win, lose, result_valid, compareEn, invalid_guess = 0.
  - resetRedWhite=1 for the reset cycle.
- States: IDLE, CLEAR, COMPARE, CAPTURE, GAME_OVER.
- IDLE + guess_submit:
  - Latch guess_in into guess; go to CLEAR.
- CLEAR (1 cycle):
  - resetRedWhite=1, compareEn=0, compare_i=0.
- COMPARE (exactly 4 cycles):
  - compareEn=1; compare_i steps 0,1,2,3.
  - curr_code = secret[3*compare_i+2 : 3*compare_i], combinational from registered compare_i.
  - After compare_i=3, go to CAPTURE.
- CAPTURE (1 cycle):
  - compareEn=0; red_in/white_in are final.
  - At the clock edge ending CAPTURE:
    - red_out<=red_in, white_out<=white_in.
    - result_valid<=1 (visible the following cycle only).
    - guess_count<=guess_count+1.
    - win<=(red_in==4).
    - lose<=(red_in!=4 && guess_count+1==MAX_GUESSES).
  - Next state: GAME_OVER if win or lose, else IDLE.
- Latency: submit sampled at edge N → result_valid high in cycle N+7; a new submit is accepted from the cycle result_valid is high.
- guess_submit outside IDLE is ignored (no queueing).
- GAME_OVER: all submits ignored; outputs hold until new_game.
- new_game:
  - Accepted in any state, including mid-COMPARE (aborts the round).
  - Loads secret_in; clears guess_count, win, lose, red_out, white_out.
  - Asserts resetRedWhite for that cycle; goes to IDLE.
  - Has priority over a simultaneous guess_submit, which is dropped.
- Last guess correct: win=1, lose=0 (win priority).
- guess_count never exceeds MAX_GUESSES; no wrap.

Optional Feature:
- Macro: GUESS_CHECK_EN.
- Defined: in IDLE, a submit with any peg ≥ NUM_COLOURS is rejected:
  - invalid_guess pulses 1 cycle; state stays IDLE.
  - guess and guess_count are unchanged.
- Not defined: every submit is accepted; invalid_guess tied 0.

Decomposition:
- Shared package mastermind_pkg holds:
  - PEG_W=3, NUM_PEGS=4, CODE_W=12.
  - The round state enum.
  - Helper function peg_of(code, idx).
- One natural sub-module: guess_validator (combinational peg range check), instantiated only under GUESS_CHECK_EN.
- The compare stage is instantiated alongside this block in the bench, not inside it.

Test Plan:
- Bench connects the real compare stage; secret 0x8D1 (pegs 1,2,3,4) unless noted.
- Exact match: new_game, submit guess 0x8D1 → 7 cycles later result_valid, red_out=4, white_out=0, win=1, guess_count=1, state GAME_OVER; a further submit is ignored.
- Permuted guess: submit 0x70A (pegs 2,1,4,3) → red_out=0, white_out=4, win=0, guess_count=1, back in IDLE.
- Exhaust guesses: MAX_GUESSES=3, submit 0x000 three times → lose=1 after third result_valid; guess_count=3; fourth submit ignored.
- Abort mid-round: new_game two cycles into COMPARE → resetRedWhite=1 next cycle, state IDLE, guess_count=0, no result_valid pulse.
- Busy/priority: submit during CLEAR is ignored; new_game and submit in the same cycle → only new_game takes effect.
- GUESS_CHECK_EN defined: submit pegs 7,0,0,0 (0x007) → invalid_guess pulse, busy stays 0, guess_count unchanged.
